// File: rtl/alu_share_arb_if.sv
// Requester-side handshake bundle for alu_share_arb: request channel
// (valid/ready with opcode and operands) plus the response handshake.
// The response data itself is a shared bus on the arbiter top.
interface alu_share_arb_if;
    logic        valid;
    logic        ready;
    logic [3:0]  opcode;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic        resp_valid;
    logic        resp_ready;

    // Requester side
    modport master (
        output valid, opcode, op_1, op_2, resp_ready,
        input  ready, resp_valid
    );

    // Arbiter side
    modport slave (
        input  valid, opcode, op_1, op_2, resp_ready,
        output ready, resp_valid
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of a single combinational ALU. The winner's
// operation is driven onto the ALU in its grant cycle and the result is
// captured into a one-entry response buffer that is held until the owner
// accepts it. Back-pressure on the buffer stalls all new grants.
module alu_share_arb #(
    parameter bit RR_EN = 1'b1   // 1: round-robin on ties, 0: req0 always wins
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_share_arb_if.slave       req0,
    alu_share_arb_if.slave       req1,
    output logic [31:0]          resp_data_o,
    output logic [3:0]           alu_opcode_o,
    output logic [31:0]          alu_op_1_o,
    output logic [31:0]          alu_op_2_o,
    input  logic [31:0]          alu_result_i
);

    typedef enum logic {
        IDLE = 1'b0,   // response buffer empty
        RESP = 1'b1    // buffer holds a result for owner_q
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] resp_data_q, resp_data_d;

    // Requester signals gathered into index-addressable form
    logic [1:0]       vld;
    logic [1:0]       resp_rdy;
    logic [1:0][3:0]  opc;
    logic [1:0][31:0] opa;
    logic [1:0][31:0] opb;

    logic [1:0] rdy;
    logic [1:0] resp_vld;
    logic       accept;
    logic       can_issue;
    logic       gnt_vld;
    logic       gnt_id;

    assign vld      = {req1.valid, req0.valid};
    assign resp_rdy = {req1.resp_ready, req0.resp_ready};
    assign opc[0]   = req0.opcode;
    assign opc[1]   = req1.opcode;
    assign opa[0]   = req0.op_1;
    assign opa[1]   = req1.op_1;
    assign opb[0]   = req0.op_2;
    assign opb[1]   = req1.op_2;

    assign req0.ready      = rdy[0];
    assign req1.ready      = rdy[1];
    assign req0.resp_valid = resp_vld[0];
    assign req1.resp_valid = resp_vld[1];
    assign resp_data_o     = resp_data_q;

    // Only the owner sees its response valid; the other requester's
    // resp_ready therefore never affects the buffer.
    always_comb begin
        resp_vld = 2'b00;
        if (state_q == RESP) resp_vld[owner_q] = 1'b1;
    end

    // Arbitration, ALU drive and next-state. A grant is allowed when the
    // buffer is empty or is being drained this very cycle, which gives
    // one op per cycle when consumers are always ready. Grants are
    // suppressed while reset is asserted so nothing is accepted and then
    // lost at the reset edge.
    always_comb begin
        accept       = (state_q == RESP) && resp_rdy[owner_q];
        can_issue    = (state_q == IDLE) || accept;
        gnt_vld      = 1'b0;
        gnt_id       = 1'b0;
        rdy          = 2'b00;
        alu_opcode_o = 4'd0;
        alu_op_1_o   = 32'd0;
        alu_op_2_o   = 32'd0;
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;

        if (!rst_i && can_issue && (vld != 2'b00)) begin
            gnt_vld = 1'b1;
            if (vld == 2'b11) gnt_id = RR_EN ? ~last_grant_q : 1'b0;
            else              gnt_id = vld[1];
        end

        if (gnt_vld) begin
            rdy[gnt_id]  = 1'b1;
            alu_opcode_o = opc[gnt_id];
            alu_op_1_o   = opa[gnt_id];
            alu_op_2_o   = opb[gnt_id];
            state_d      = RESP;
            owner_d      = gnt_id;
            last_grant_d = gnt_id;
            resp_data_d  = alu_result_i;
        end else if (accept) begin
            state_d = IDLE;
        end
    end

    // State and response buffer registers; reset drops any pending result
    // and leaves last_grant at 1 so req0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vectors, scoreboard of expected
// responses pushed on each accepted request and popped by a negedge monitor.
// A second, fixed-priority instance mirrors the same request stimulus.
module tb_alu_share_arb;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

    logic clk_i;
    logic rst_i;

    alu_share_arb_if r0 ();
    alu_share_arb_if r1 ();
    alu_share_arb_if f0 ();
    alu_share_arb_if f1 ();

    logic [31:0] resp_data, alu_a, alu_b, alu_res;
    logic [3:0]  alu_opc;
    logic [31:0] f_data, f_a, f_b, f_res;
    logic [3:0]  f_opc;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Stand-in ALU
    function automatic logic [31:0] alu_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_model(alu_opc, alu_a, alu_b);
    assign f_res   = alu_model(f_opc, f_a, f_b);

    // Fixed-priority instance sees the same requests, always consumes
    assign f0.valid      = r0.valid;
    assign f0.opcode     = r0.opcode;
    assign f0.op_1       = r0.op_1;
    assign f0.op_2       = r0.op_2;
    assign f0.resp_ready = 1'b1;
    assign f1.valid      = r1.valid;
    assign f1.opcode     = r1.opcode;
    assign f1.op_1       = r1.op_1;
    assign f1.op_2       = r1.op_2;
    assign f1.resp_ready = 1'b1;

    alu_share_arb #(.RR_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req0(r0.slave), .req1(r1.slave),
        .resp_data_o(resp_data), .alu_opcode_o(alu_opc),
        .alu_op_1_o(alu_a), .alu_op_2_o(alu_b), .alu_result_i(alu_res)
    );

    alu_share_arb #(.RR_EN(1'b0)) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i), .req0(f0.slave), .req1(f1.slave),
        .resp_data_o(f_data), .alu_opcode_o(f_opc),
        .alu_op_1_o(f_a), .alu_op_2_o(f_b), .alu_result_i(f_res)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the presented response against the scoreboard head,
    // pops on acceptance, then records newly accepted requests.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (r0.resp_valid && r1.resp_valid) begin
                chk("resp_onehot", {r1.resp_valid, r0.resp_valid}, 32'd1);
            end else if (r0.resp_valid || r1.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("resp_owner", r1.resp_valid, exp_q[0].own);
                    chk("resp_data", resp_data, exp_q[0].data);
                    if (r1.resp_valid ? r1.resp_ready : r0.resp_ready)
                        void'(exp_q.pop_front());
                end
            end else begin
                chk("resp_missing", exp_q.size(), 32'd0);
            end
            if (r0.valid && r0.ready) begin
                chk("alu_drive0", {alu_opc, alu_a[13:0], alu_b[13:0]},
                    {r0.opcode, r0.op_1[13:0], r0.op_2[13:0]});
                exp_q.push_back('{own: 1'b0, data: alu_model(r0.opcode, r0.op_1, r0.op_2)});
            end
            if (r1.valid && r1.ready) begin
                chk("alu_drive1", {alu_opc, alu_a[13:0], alu_b[13:0]},
                    {r1.opcode, r1.op_1[13:0], r1.op_2[13:0]});
                exp_q.push_back('{own: 1'b1, data: alu_model(r1.opcode, r1.op_1, r1.op_2)});
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input bit n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (n) begin r1.valid = v; r1.opcode = op; r1.op_1 = a; r1.op_2 = b; end
        else   begin r0.valid = v; r0.opcode = op; r0.op_1 = a; r0.op_2 = b; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_exp;
        rst_i = 1'b1;
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        r0.resp_ready = 1'b1;
        r1.resp_ready = 1'b1;
        step(); step();
        rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        chk("rst_resp_valid", {r1.resp_valid, r0.resp_valid}, 32'd0);
        chk("rst_ready", {r1.ready, r0.ready}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_alu", {alu_opc, alu_a[27:0]}, 32'd0);

        // 1: single req0 ADD 5+7
        step();
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        @(negedge clk_i);
        chk("t1_ready", {r1.ready, r0.ready}, 32'd1);
        chk("t1_alu_a", alu_a, 32'd5);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk_i);
        chk("t1_resp_valid", r0.resp_valid, 32'd1);
        chk("t1_data", resp_data, 32'd12);
        step();
        @(negedge clk_i);
        chk("t1_idle", {r1.resp_valid, r0.resp_valid}, 32'd0);
        chk("t1_alu_idle", alu_opc, 32'd0);

        // 2/3: both valid; round-robin alternates starting with req1 (req0
        // won last), fixed-priority instance grants req0 every cycle
        step();
        set_req(0, 1'b1, OP_ADD, 32'd100, 32'd1);
        set_req(1, 1'b1, OP_SUB, 32'd50, 32'd8);
        rr_exp = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t2_rr_grant", {r1.ready, r0.ready}, rr_exp);
            chk("t3_fp_grant", {f1.ready, f0.ready}, 32'd1);
            if (i > 0) chk("t3_fp_data", f_data, 32'd101);
            rr_exp = ~rr_exp;
        end
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        step();

        // 4: req1 SUB 3-10 held by back-pressure, req0 waits
        r1.resp_ready = 1'b0;
        set_req(1, 1'b1, OP_SUB, 32'd3, 32'd10);
        @(negedge clk_i);
        chk("t4_ready1", {r1.ready, r0.ready}, 32'd2);
        step();
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t4_blocked", {r1.ready, r0.ready}, 32'd0);
            chk("t4_hold", resp_data, 32'hFFFFFFF9);
        end
        step();
        r1.resp_ready = 1'b1;
        @(negedge clk_i);
        chk("t4_accept_grant", {r1.ready, r0.ready}, 32'd1);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk_i);
        chk("t4_data0", resp_data, 32'd3);
        step();

        // 5: non-owner resp_ready pulse is ignored
        r0.resp_ready = 1'b0;
        r1.resp_ready = 1'b0;
        set_req(0, 1'b1, OP_XOR, 32'h0000F0F0, 32'h00000FF0);
        @(negedge clk_i);
        chk("t5_ready0", r0.ready, 32'd1);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        step();
        r1.resp_ready = 1'b1;
        step();
        r1.resp_ready = 1'b0;
        @(negedge clk_i);
        chk("t5_still_valid", {r1.resp_valid, r0.resp_valid}, 32'd1);
        chk("t5_data", resp_data, 32'h0000FF00);
        step();
        r0.resp_ready = 1'b1;
        step();
        @(negedge clk_i);
        chk("t5_drained", r0.resp_valid, 32'd0);

        // 6: reset while holding a response
        step();
        set_req(1, 1'b1, OP_OR, 32'h00000F00, 32'h000000F0);
        @(negedge clk_i);
        chk("t6_ready1", r1.ready, 32'd1);
        step();
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk_i);
        chk("t6_pending", resp_data, 32'h00000FF0);
        step();
        rst_i = 1'b1;
        set_req(0, 1'b1, OP_AND, 32'hFF00FF00, 32'h0F0F0F0F);
        set_req(1, 1'b1, OP_SUB, 32'd9, 32'd4);
        @(negedge clk_i);
        chk("t6_rst_ready", {r1.ready, r0.ready}, 32'd0);
        chk("t6_rst_alu", alu_opc, 32'd0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6_post_resp_valid", {r1.resp_valid, r0.resp_valid}, 32'd0);
        chk("t6_post_data", resp_data, 32'd0);
        chk("t6_tie_req0", {r1.ready, r0.ready}, 32'd1);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        r1.resp_ready = 1'b1;
        @(negedge clk_i);
        chk("t6_and_data", resp_data, 32'h0F000F00);
        step(); step();
        @(negedge clk_i);
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
